// File: rtl/eq_sched_pkg.sv
// ---------------------------------------------------------------------------
// eq_sched_pkg
// Shared types, default parameters and gain arithmetic helpers for the EQ
// gain scheduler.
//   state_t     : scheduler FSM states (S_IDLE / S_SCAN / S_CLEAR)
//   band_t      : 3-bit band index
//   gain_t      : signed two's complement gain word
//   gain_clamp  : saturates a requested gain into [lo, hi]
//   gain_step   : moves cur toward tgt by at most step
// ---------------------------------------------------------------------------
package eq_sched_pkg;

  localparam int NBAND_DEF    = 6;
  localparam int GW_DEF       = 16;
  localparam int GAIN_MIN_DEF = -11;
  localparam int GAIN_MAX_DEF = 12;
  localparam int STEP_DEF     = 1;

  typedef logic [2:0] band_t;
  typedef logic signed [GW_DEF-1:0] gain_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SCAN  = 2'd1,
    S_CLEAR = 2'd2
  } state_t;

  // Saturating clamp; the bounds are narrowed once so the compares are
  // plain signed GW-bit compares.
  function automatic gain_t gain_clamp(input gain_t g, input int lo, input int hi);
    gain_t lo_g;
    gain_t hi_g;
    lo_g = gain_t'(lo);
    hi_g = gain_t'(hi);
    if (g < lo_g) begin
      return lo_g;
    end else if (g > hi_g) begin
      return hi_g;
    end else begin
      return g;
    end
  endfunction

  // The difference is formed one bit wider than the gain word so that a
  // large span between cur and tgt can never wrap and reverse the ramp.
  function automatic gain_t gain_step(input gain_t cur, input gain_t tgt, input int step);
    logic signed [GW_DEF:0] diff;
    logic signed [GW_DEF:0] lim;
    diff = {tgt[GW_DEF-1], tgt} - {cur[GW_DEF-1], cur};
    lim  = (GW_DEF+1)'(step);
    if (diff > lim) begin
      return cur + gain_t'(step);
    end else if (diff < -lim) begin
      return cur - gain_t'(step);
    end else begin
      return tgt;
    end
  endfunction

endpackage

// File: rtl/eq_gain_scheduler.sv
// ---------------------------------------------------------------------------
// eq_gain_scheduler
// Owns per-band EQ gain state between the menu FSM and the DSP coefficient
// port. The menu posts target gains; on each sample frame every band's
// applied gain is moved one ramp step toward its target and each change is
// emitted as a single-cycle coefficient write.
//
// Ports
//   i_clk        : clock (BCLK domain)
//   i_rst_n      : synchronous reset, active low
//   i_frame      : one-cycle pulse per sample frame
//   i_req_valid  : target-gain request valid
//   i_req_band   : band index of request
//   i_req_gain   : requested target gain (signed)
//   o_req_ready  : request accepted when valid & ready
//   i_clear      : one-cycle pulse, all targets return to 0
//   o_dsp_we     : one-cycle coefficient write strobe
//   o_dsp_band   : band being written
//   o_dsp_gain   : new applied gain for o_dsp_band
//   o_busy       : high while scanning or clearing
//   o_overrun    : sticky, a frame was dropped
//   o_req_err    : one-cycle pulse, accepted request named a missing band
// ---------------------------------------------------------------------------
module eq_gain_scheduler
  import eq_sched_pkg::*;
#(
  parameter int NBAND    = NBAND_DEF,
  parameter int GW       = GW_DEF,
  parameter int GAIN_MIN = GAIN_MIN_DEF,
  parameter int GAIN_MAX = GAIN_MAX_DEF,
  parameter int STEP     = STEP_DEF
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_frame,
  input  logic                 i_req_valid,
  input  logic [2:0]           i_req_band,
  input  logic signed [GW-1:0] i_req_gain,
  output logic                 o_req_ready,
  input  logic                 i_clear,
  output logic                 o_dsp_we,
  output logic [2:0]           o_dsp_band,
  output logic signed [GW-1:0] o_dsp_gain,
  output logic                 o_busy,
  output logic                 o_overrun,
  output logic                 o_req_err
);

  localparam band_t LAST_BAND = band_t'(NBAND);

  state_t state;
  state_t state_next;
  band_t  idx;
  band_t  idx_next;

  gain_t tgt [0:NBAND];
  gain_t cur [0:NBAND];

  logic  pending;
  logic  clear_pend;

  logic  last;
  logic  clear_hit;
  logic  req_accept;
  logic  frame_direct;
  logic  frame_queued;
  logic  consume;
  logic  scan_diff;
  gain_t step_val;

  // A clear arriving this cycle blocks the request so clear always wins.
  assign o_req_ready = (state != S_CLEAR) && !i_clear;
  assign req_accept  = i_req_valid && o_req_ready;

  // The scan reads the targets before this edge's request write lands, so a
  // request colliding with the visit takes effect on the following frame.
  always_comb begin
    scan_diff = (state == S_SCAN) && (cur[idx] != tgt[idx]);
    step_val  = gain_step(cur[idx], tgt[idx], STEP);
  end

  always_comb begin
    state_next = state;
    idx_next   = idx;
    last       = (idx == LAST_BAND);
    clear_hit  = clear_pend || i_clear;
    case (state)
      S_IDLE: begin
        if (i_clear) begin
          state_next = S_CLEAR;
        end else if (i_frame || pending) begin
          state_next = S_SCAN;
          idx_next   = '0;
        end
      end
      S_SCAN: begin
        if (last) begin
          if (clear_hit) begin
            state_next = S_CLEAR;
          end else if (pending) begin
            state_next = S_SCAN;
            idx_next   = '0;
          end else begin
            state_next = S_IDLE;
          end
        end else begin
          idx_next = idx + band_t'(1);
        end
      end
      S_CLEAR: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Frame bookkeeping: a frame either starts an idle scan directly or is
  // queued in pending; a queued frame arriving while one is already waiting
  // (and not being consumed this edge) is the overrun case.
  always_comb begin
    frame_direct = (state == S_IDLE) && !i_clear && !pending && i_frame;
    frame_queued = i_frame && !frame_direct;
    consume      = pending &&
                   (((state == S_IDLE) && !i_clear) ||
                    ((state == S_SCAN) && last && !clear_hit));
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state <= S_IDLE;
      idx   <= '0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int b = 0; b <= NBAND; b++) begin
        tgt[b] <= '0;
        cur[b] <= '0;
      end
      pending    <= 1'b0;
      clear_pend <= 1'b0;
      o_dsp_we   <= 1'b0;
      o_dsp_band <= '0;
      o_dsp_gain <= '0;
      o_busy     <= 1'b0;
      o_overrun  <= 1'b0;
      o_req_err  <= 1'b0;
    end else begin
      o_dsp_we  <= 1'b0;
      o_req_err <= 1'b0;
      o_busy    <= (state_next != S_IDLE);

      if (scan_diff) begin
        cur[idx]   <= step_val;
        o_dsp_we   <= 1'b1;
        o_dsp_band <= idx;
        o_dsp_gain <= step_val;
      end

      if (state == S_CLEAR) begin
        for (int b = 0; b <= NBAND; b++) begin
          tgt[b] <= '0;
        end
        clear_pend <= 1'b0;
      end else begin
        if ((state == S_SCAN) && i_clear) begin
          clear_pend <= 1'b1;
        end
        if (req_accept) begin
          if (i_req_band > LAST_BAND) begin
            o_req_err <= 1'b1;
          end else begin
            tgt[i_req_band] <= gain_clamp(i_req_gain, GAIN_MIN, GAIN_MAX);
          end
        end
      end

      if (frame_queued) begin
        if (pending && !consume) begin
          o_overrun <= 1'b1;
        end else begin
          pending <= 1'b1;
        end
      end else if (consume) begin
        pending <= 1'b0;
      end
    end
  end

endmodule
